// File: rtl/qspi_flash_reader.sv
// Single-bit SPI READ (0x03) sequencer: turns (addr, len) requests into flash reads and
// streams the returned bytes over valid/ready, freezing SCK while the consumer stalls.
module qspi_flash_reader #(
  parameter int CLK_DIV   = 2,
  parameter int CS_IDLE   = 4,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_req_valid,
  output logic                 io_req_ready,
  input  logic [23:0]          io_req_addr,
  input  logic [LEN_WIDTH-1:0] io_req_len,
  output logic                 io_resp_valid,
  input  logic                 io_resp_ready,
  output logic [7:0]           io_resp_data,
  output logic                 io_resp_last,
  output logic                 io_busy,
  output logic                 io_spi_sck,
  output logic                 io_spi_cs,
  output logic                 io_spi_mosi,
  input  logic                 io_spi_miso
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, STALL, GAP} state_t;

  localparam logic [15:0]          DIV_LAST     = 16'(CLK_DIV - 1);
  localparam logic [15:0]          GAP_LAST     = 16'(CS_IDLE - 1);
  localparam logic [15:0]          GAP_ZERO_LEN = 16'(CS_IDLE);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE      = LEN_WIDTH'(1);

  state_t               state_q, state_d;
  logic [15:0]          div_cnt_q, div_cnt_d;
  logic [15:0]          gap_cnt_q, gap_cnt_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [30:0]          tx_q, tx_d;
  logic [7:0]           rx_q, rx_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic                 sck_q, sck_d;
  logic                 cs_q, cs_d;
  logic                 mosi_q, mosi_d;
  logic                 req_ready_q, req_ready_d;
  logic                 busy_q, busy_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_last_q, resp_last_d;
  logic [7:0]           resp_data_q, resp_data_d;
  logic                 resp_fire, buf_free, deliver;

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    rem_d        = rem_q;
    sck_d        = sck_q;
    cs_d         = cs_q;
    mosi_d       = mosi_q;
    resp_valid_d = resp_valid_q;
    resp_last_d  = resp_last_q;
    resp_data_d  = resp_data_q;
    deliver      = 1'b0;
    resp_fire    = resp_valid_q && io_resp_ready;
    buf_free     = !resp_valid_q || io_resp_ready;

    if (resp_fire) begin
      resp_valid_d = 1'b0;
      resp_last_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_ready_q && io_req_valid) begin
          if (io_req_len == '0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_ZERO_LEN;
          end else begin
            state_d   = CMD;
            cs_d      = 1'b0;
            mosi_d    = 1'b0;
            tx_d      = {7'h03, io_req_addr};
            rem_d     = io_req_len;
            bit_cnt_d = 5'd7;
            div_cnt_d = '0;
            sck_d     = 1'b0;
          end
        end
      end
      CMD, ADDR, DATA: begin
        if (div_cnt_q != DIV_LAST) begin
          div_cnt_d = div_cnt_q + 16'd1;
        end else begin
          div_cnt_d = '0;
          sck_d     = !sck_q;
          if (!sck_q) begin
            if (state_q == DATA) rx_d = {rx_q[6:0], io_spi_miso};
          end else begin
            // End of a bit: MOSI advances together with the falling SCK edge.
            mosi_d = tx_q[30];
            tx_d   = {tx_q[29:0], 1'b0};
            if (bit_cnt_q != 5'd0) begin
              bit_cnt_d = bit_cnt_q - 5'd1;
            end else begin
              case (state_q)
                CMD: begin
                  state_d   = ADDR;
                  bit_cnt_d = 5'd23;
                end
                ADDR: begin
                  state_d   = DATA;
                  bit_cnt_d = 5'd7;
                end
                default: begin
                  if (buf_free) deliver = 1'b1;
                  else          state_d = STALL;
                end
              endcase
            end
          end
        end
      end
      STALL: begin
        if (resp_fire) deliver = 1'b1;
      end
      GAP: begin
        if (gap_cnt_q != 16'd0) gap_cnt_d = gap_cnt_q - 16'd1;
        else if (buf_free)      state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A completed byte enters the single output buffer; the last one also releases CS.
    if (deliver) begin
      resp_valid_d = 1'b1;
      resp_data_d  = rx_q;
      resp_last_d  = (rem_q == LEN_ONE);
      rem_d        = rem_q - LEN_ONE;
      div_cnt_d    = '0;
      sck_d        = 1'b0;
      if (rem_q == LEN_ONE) begin
        state_d   = GAP;
        cs_d      = 1'b1;
        gap_cnt_d = GAP_LAST;
      end else begin
        state_d   = DATA;
        bit_cnt_d = 5'd7;
      end
    end

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      rem_q        <= '0;
      sck_q        <= 1'b0;
      cs_q         <= 1'b1;
      mosi_q       <= 1'b0;
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      rem_q        <= rem_d;
      sck_q        <= sck_d;
      cs_q         <= cs_d;
      mosi_q       <= mosi_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_last_q  <= resp_last_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign io_req_ready  = req_ready_q;
  assign io_busy       = busy_q;
  assign io_resp_valid = resp_valid_q;
  assign io_resp_last  = resp_last_q;
  assign io_resp_data  = resp_data_q;
  assign io_spi_sck    = sck_q;
  assign io_spi_cs     = cs_q;
  assign io_spi_mosi   = mosi_q;

endmodule

// File: tb/tb_qspi_flash_reader.sv
// Directed bench for qspi_flash_reader with a behavioural mode-0 SPI flash model.
module tb_qspi_flash_reader;

  localparam int CLK_DIV   = 2;
  localparam int CS_IDLE   = 4;
  localparam int LEN_WIDTH = 16;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 io_req_valid = 1'b0;
  logic                 io_req_ready;
  logic [23:0]          io_req_addr = '0;
  logic [LEN_WIDTH-1:0] io_req_len = '0;
  logic                 io_resp_valid;
  logic                 io_resp_ready = 1'b1;
  logic [7:0]           io_resp_data;
  logic                 io_resp_last;
  logic                 io_busy;
  logic                 io_spi_sck;
  logic                 io_spi_cs;
  logic                 io_spi_mosi;
  logic                 io_spi_miso = 1'b0;

  int checks = 0;
  int errors = 0;

  qspi_flash_reader #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE), .LEN_WIDTH(LEN_WIDTH)) dut (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_addr(io_req_addr), .io_req_len(io_req_len),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_data(io_resp_data), .io_resp_last(io_resp_last),
    .io_busy(io_busy), .io_spi_sck(io_spi_sck), .io_spi_cs(io_spi_cs),
    .io_spi_mosi(io_spi_mosi), .io_spi_miso(io_spi_miso)
  );

  always #5 clock = ~clock;

  // Flash model: captures command+address on SCK rises, drives data on SCK falls.
  int          flash_bits = 0;
  int          sck_rises  = 0;
  logic [31:0] flash_cap  = '0;
  int          miso_off;
  logic [7:0]  miso_byte;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return (a == 24'h000010) ? 8'hA5 : a[7:0];
  endfunction

  always @(posedge io_spi_sck or posedge io_spi_cs) begin
    if (io_spi_cs) begin
      flash_bits <= 0;
    end else begin
      if (flash_bits < 32) flash_cap <= {flash_cap[30:0], io_spi_mosi};
      flash_bits <= flash_bits + 1;
      sck_rises  <= sck_rises + 1;
    end
  end

  always @(negedge io_spi_sck) begin
    if (!io_spi_cs && flash_bits >= 32) begin
      miso_off    = flash_bits - 32;
      miso_byte   = flash_byte(flash_cap[23:0] + 24'(miso_off / 8));
      io_spi_miso = miso_byte[7 - (miso_off % 8)];
    end
  end

  // Per-request observations gathered by run_request.
  int         beats, first_valid, cs_rise, busy_drop, ready_low, rises;
  logic [7:0] beat_data [8];
  logic       beat_last [8];
  int         beat_cyc  [8];
  logic [7:0] first_data;
  logic       cs_low_seen, sck_high_seen, hold_sck_high, hold_cs_high, hold_data_changed;
  logic       timed_out;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 1000 && !io_req_ready; i++) tick();
  endtask

  task automatic run_request(input logic [23:0] addr, input logic [LEN_WIDTH-1:0] len,
                             input int hold);
    int   start_rises;
    logic cs_was_low;
    wait_ready();
    beats = 0; first_valid = -1; cs_rise = -1; busy_drop = -1; ready_low = 0;
    cs_low_seen = 1'b0; sck_high_seen = 1'b0; hold_sck_high = 1'b0; hold_cs_high = 1'b0;
    hold_data_changed = 1'b0; timed_out = 1'b1; cs_was_low = 1'b0; first_data = '0;
    start_rises = sck_rises;
    io_req_addr = addr; io_req_len = len; io_req_valid = 1'b1; io_resp_ready = 1'b1;
    tick();
    io_req_valid = 1'b0;
    for (int k = 1; k < 3000; k++) begin
      if (io_resp_valid && first_valid < 0) begin
        first_valid = k;
        first_data  = io_resp_data;
      end
      if (!io_spi_cs) begin
        cs_low_seen = 1'b1;
        cs_was_low  = 1'b1;
      end else if (cs_was_low && cs_rise < 0) begin
        cs_rise = k;
      end
      if (io_spi_sck) sck_high_seen = 1'b1;
      if (!io_req_ready) ready_low++;
      if (hold > 0 && first_valid >= 0 && k > first_valid + 40 && k < first_valid + hold) begin
        if (io_spi_sck) hold_sck_high = 1'b1;
        if (io_spi_cs) hold_cs_high = 1'b1;
        if (!io_resp_valid || io_resp_data !== first_data) hold_data_changed = 1'b1;
      end
      io_resp_ready = (hold == 0) || (first_valid < 0) || (k >= first_valid + hold);
      if (io_resp_valid && io_resp_ready) begin
        if (beats < 8) begin
          beat_data[beats] = io_resp_data;
          beat_last[beats] = io_resp_last;
          beat_cyc[beats]  = k;
        end
        beats++;
      end
      if (!io_busy) begin
        busy_drop = k;
        timed_out = 1'b0;
        break;
      end
      tick();
    end
    io_resp_ready = 1'b1;
    rises = sck_rises - start_rises;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({io_req_ready, io_resp_valid, io_resp_last, io_busy, io_spi_sck, io_spi_cs, io_spi_mosi} !== 7'b0000010) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000010", {io_req_ready, io_resp_valid, io_resp_last, io_busy, io_spi_sck, io_spi_cs, io_spi_mosi});
    end
    checks++;
    if (io_resp_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected 00", io_resp_data);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (io_req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_hold: req_ready got %b expected 0", io_req_ready);
    end
    tick();
    checks++;
    if (io_req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: req_ready got %b expected 1", io_req_ready);
    end
  endtask

  task automatic test_single();
    run_request(24'h000010, 16'd1, 0);
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL single_timeout: got %b expected 0", timed_out); end
    checks++;
    if (flash_cap !== 32'h03000010) begin errors++; $display("[TB] FAIL single_cmd_addr: got %h expected 03000010", flash_cap); end
    checks++;
    if (first_valid != 161) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 161", first_valid); end
    checks++;
    if (beats != 1) begin errors++; $display("[TB] FAIL single_beats: got %0d expected 1", beats); end
    checks++;
    if (beat_data[0] !== 8'hA5 || beat_last[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL single_data: got %h last %b expected a5 last 1", beat_data[0], beat_last[0]);
    end
    checks++;
    if (cs_rise != 161) begin errors++; $display("[TB] FAIL single_cs_rise: got %0d expected 161", cs_rise); end
    checks++;
    if (busy_drop != 161 + CS_IDLE) begin errors++; $display("[TB] FAIL single_busy_drop: got %0d expected %0d", busy_drop, 161 + CS_IDLE); end
    checks++;
    if (rises != 40) begin errors++; $display("[TB] FAIL single_sck_rises: got %0d expected 40", rises); end
  endtask

  task automatic test_burst();
    run_request(24'h000000, 16'd4, 0);
    checks++;
    if (beats != 4 || timed_out !== 1'b0) begin errors++; $display("[TB] FAIL burst_beats: got %0d timeout %b expected 4", beats, timed_out); end
    checks++;
    if (flash_cap !== 32'h03000000) begin errors++; $display("[TB] FAIL burst_cmd_addr: got %h expected 03000000", flash_cap); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (beat_data[i] !== 8'(i) || beat_last[i] !== (i == 3)) begin
        errors++; $display("[TB] FAIL burst_beat%0d: got %h last %b expected %h last %b", i, beat_data[i], beat_last[i], 8'(i), i == 3);
      end
      if (i > 0) begin
        checks++;
        if (beat_cyc[i] - beat_cyc[i-1] != 32) begin
          errors++; $display("[TB] FAIL burst_spacing%0d: got %0d expected 32", i, beat_cyc[i] - beat_cyc[i-1]);
        end
      end
    end
    checks++;
    if (rises != 64) begin errors++; $display("[TB] FAIL burst_sck_rises: got %0d expected 64", rises); end
  endtask

  task automatic test_stall();
    run_request(24'h0000C8, 16'd4, 200);
    checks++;
    if (hold_sck_high !== 1'b0 || hold_cs_high !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_frozen: sck_high %b cs_high %b expected 0 0", hold_sck_high, hold_cs_high);
    end
    checks++;
    if (hold_data_changed !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold_data: changed %b expected 0", hold_data_changed); end
    checks++;
    if (beats != 4 || timed_out !== 1'b0) begin errors++; $display("[TB] FAIL stall_beats: got %0d timeout %b expected 4", beats, timed_out); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (beat_data[i] !== 8'(8'hC8 + i) || beat_last[i] !== (i == 3)) begin
        errors++; $display("[TB] FAIL stall_beat%0d: got %h last %b expected %h last %b", i, beat_data[i], beat_last[i], 8'(8'hC8 + i), i == 3);
      end
    end
    checks++;
    if (rises != 64) begin errors++; $display("[TB] FAIL stall_sck_rises: got %0d expected 64", rises); end
  endtask

  task automatic test_zero_len();
    run_request(24'h000055, 16'd0, 0);
    checks++;
    if (beats != 0) begin errors++; $display("[TB] FAIL zero_beats: got %0d expected 0", beats); end
    checks++;
    if (ready_low != CS_IDLE + 1) begin errors++; $display("[TB] FAIL zero_ready_low: got %0d expected %0d", ready_low, CS_IDLE + 1); end
    checks++;
    if (cs_low_seen !== 1'b0 || sck_high_seen !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_spi_idle: cs_low %b sck_high %b expected 0 0", cs_low_seen, sck_high_seen);
    end
    checks++;
    if (busy_drop != CS_IDLE + 2) begin errors++; $display("[TB] FAIL zero_busy_drop: got %0d expected %0d", busy_drop, CS_IDLE + 2); end
  endtask

  task automatic test_reset_mid();
    wait_ready();
    io_req_addr = 24'h000040; io_req_len = 16'd2; io_req_valid = 1'b1;
    tick();
    io_req_valid = 1'b0;
    repeat (49) tick();
    checks++;
    if (io_spi_cs !== 1'b0) begin errors++; $display("[TB] FAIL midreset_precond: cs got %b expected 0", io_spi_cs); end
    reset = 1'b0;
    tick();
    checks++;
    if ({io_spi_cs, io_spi_sck, io_resp_valid, io_busy} !== 4'b1000) begin
      errors++; $display("[TB] FAIL midreset_abort: cs,sck,valid,busy got %b expected 1000", {io_spi_cs, io_spi_sck, io_resp_valid, io_busy});
    end
    reset = 1'b1;
    tick();
    run_request(24'h000010, 16'd1, 0);
    checks++;
    if (beats != 1 || beat_data[0] !== 8'hA5 || first_valid != 161) begin
      errors++; $display("[TB] FAIL midreset_recover: beats %0d data %h latency %0d expected 1 a5 161", beats, beat_data[0], first_valid);
    end
  endtask

  task automatic test_back_to_back();
    int   hs, hs1, hs2, b2b_cs_rise, b2b_cs_fall, b2b_beats;
    logic prev_cs, done;
    logic [7:0] b2b_data [2];
    hs = 0; hs1 = -1; hs2 = -1; b2b_cs_rise = -1; b2b_cs_fall = -1; b2b_beats = 0;
    prev_cs = 1'b1; done = 1'b0; b2b_data[0] = '0; b2b_data[1] = '0;
    wait_ready();
    io_req_addr = 24'h000020; io_req_len = 16'd1; io_req_valid = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if (io_req_valid && io_req_ready) begin
        if (hs == 0) hs1 = k; else hs2 = k;
        hs++;
      end
      if (hs >= 1 && io_spi_cs && !prev_cs && b2b_cs_rise < 0) b2b_cs_rise = k;
      if (hs == 2 && !io_spi_cs && prev_cs && b2b_cs_fall < 0) b2b_cs_fall = k;
      if (io_resp_valid && io_resp_ready) begin
        if (b2b_beats < 2) b2b_data[b2b_beats] = io_resp_data;
        b2b_beats++;
      end
      if (hs == 2 && k > hs2 && !io_busy) begin
        done = 1'b1;
        break;
      end
      prev_cs = io_spi_cs;
      tick();
      if (hs == 2) io_req_valid = 1'b0;
    end
    io_req_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || hs != 2 || hs1 != 0) begin errors++; $display("[TB] FAIL b2b_handshakes: got %0d done %b first %0d expected 2 1 0", hs, done, hs1); end
    checks++;
    if (b2b_cs_rise < 0 || hs2 - b2b_cs_rise < CS_IDLE) begin
      errors++; $display("[TB] FAIL b2b_gap: second handshake %0d cs rise %0d need distance >= %0d", hs2, b2b_cs_rise, CS_IDLE);
    end
    checks++;
    if (b2b_cs_fall < 0 || b2b_cs_fall - b2b_cs_rise < CS_IDLE) begin
      errors++; $display("[TB] FAIL b2b_cs_high: rise %0d fall %0d need high >= %0d", b2b_cs_rise, b2b_cs_fall, CS_IDLE);
    end
    checks++;
    if (b2b_beats != 2 || b2b_data[0] !== 8'h20 || b2b_data[1] !== 8'h20) begin
      errors++; $display("[TB] FAIL b2b_data: beats %0d data %h %h expected 2 20 20", b2b_beats, b2b_data[0], b2b_data[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_stall();
    test_zero_len();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
